// File: rtl/tb_mem_pkg.sv
// Shared constants, response metadata and address-range helper for the multi-port
// testbench memory.
package tb_mem_pkg;

  localparam int MAX_PORT   = 8;
  localparam int MAX_RD_LAT = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Port-independent part of a response; the data word is appended by the memory,
  // whose width is a parameter of that module.
  typedef struct packed {
    logic       valid;
    logic [2:0] port;
    logic       err;
  } resp_meta_t;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input int shift, input logic [31:0] depth);
    logic [31:0] word;
    word = (addr - base) >> shift;
    return (addr >= base) && (word < depth);
  endfunction

endpackage

// File: rtl/tb_mem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant combinational from req, pointer names the
// highest-priority port and moves past each granted port.
module tb_mem_rr_arbiter #(
  parameter int NUM = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NUM-1:0] req,
  input  logic           stall,
  output logic [NUM-1:0] gnt
);

  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM - 1);

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int i = 0; i < NUM; i++) begin
      if (!found && req[idx] && !stall && reset_n) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_d    = (idx == LAST) ? '0 : idx + 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tb_memory_mp.sv
// Multi-port OBI-style simulation memory: RR arbitration onto one word array and a
// fixed-latency response pipe. Optional grant stalls with TB_MEMORY_MP_STALL_EN.
module tb_memory_mp
  import tb_mem_pkg::*;
#(
  parameter int          NUM_PORT  = 2,
  parameter int          DEPTH     = 4096,
  parameter int          DATA_W    = 32,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_PORT-1:0]        req,
  input  logic [NUM_PORT-1:0]        we,
  input  logic [NUM_PORT*32-1:0]     addr,
  input  logic [NUM_PORT*DATA_W-1:0] wdata,
  input  logic [NUM_PORT*DATA_W/8-1:0] be,
  output logic [NUM_PORT-1:0]        gnt,
  output logic [NUM_PORT-1:0]        rvalid,
  output logic [NUM_PORT*DATA_W-1:0] rdata,
  output logic [NUM_PORT-1:0]        err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFF_W = $clog2(BE_W);

  typedef struct packed {
    resp_meta_t        meta;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  logic stall;

`ifdef TB_MEMORY_MP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps x^16+x^14+x^13+x^11
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  tb_mem_rr_arbiter #(.NUM(NUM_PORT)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .stall   (stall),
    .gnt     (gnt)
  );

  logic              any_gnt, sel_we, sel_ok;
  logic [2:0]        sel_port;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_word;
  logic [BE_W-1:0]   sel_be;
  logic [AW-1:0]     word_idx;

  always_comb begin
    any_gnt   = 1'b0;
    sel_port  = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (gnt[p]) begin
        any_gnt   = 1'b1;
        sel_port  = 3'(p);
        sel_we    = we[p];
        sel_addr  = addr[p*32 +: 32];
        sel_wdata = wdata[p*DATA_W +: DATA_W];
        sel_be    = be[p*BE_W +: BE_W];
      end
    end
  end

  assign sel_ok   = in_range(sel_addr, BASE_ADDR, OFF_W, 32'(DEPTH));
  assign word_idx = AW'((sel_addr - BASE_ADDR) >> OFF_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; the program image is loaded
  // into it from outside, and resetting storage would only cost a huge reset fan-out.
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we && sel_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Combinational read in the grant cycle sees a write committed at the previous edge.
  assign rd_word = (any_gnt && sel_ok && !sel_we) ? mem[word_idx] : '0;

  resp_t pipe_q [RD_LAT];
  resp_t pipe_d [RD_LAT];
  resp_t out_resp;

  always_comb begin
    pipe_d[0].meta.valid = any_gnt;
    pipe_d[0].meta.port  = sel_port;
    pipe_d[0].meta.err   = any_gnt && !sel_ok;
    pipe_d[0].rdata      = rd_word;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign out_resp = pipe_q[RD_LAT-1];

  always_comb begin
    rvalid = '0;
    err    = '0;
    rdata  = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (out_resp.meta.valid && out_resp.meta.port == 3'(p)) begin
        rvalid[p]                  = 1'b1;
        err[p]                     = out_resp.meta.err;
        rdata[p*DATA_W +: DATA_W]  = out_resp.rdata;
      end
    end
  end

endmodule

// File: tb/tb_tb_memory_mp.sv
// Scoreboard bench for tb_memory_mp (2 ports, RD_LAT=2): drivers push expected
// responses, a negedge monitor pops and compares whenever rvalid is seen.
module tb_tb_memory_mp;

  localparam int NP  = 2;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] req, we, gnt, rvalid, err;
  logic [63:0]   addr, wdata, rdata;
  logic [7:0]    be;

  always #5 clk = ~clk;

  tb_memory_mp #(
    .NUM_PORT (NP),
    .DEPTH    (4096),
    .DATA_W   (32),
    .RD_LAT   (LAT),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .err     (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic model_stall;
`ifdef TB_MEMORY_MP_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
  assign model_stall = (lfsr_m[1:0] == 2'b00);
`else
  assign model_stall = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic e, input logic [31:0] d);
    exp_t x;
    x.err  = e;
    x.data = d;
    x.due  = cyc + LAT;
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] r, input int ptr, input logic st);
    if (st) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (r[(ptr + i) % 2]) return 2'(1 << ((ptr + i) % 2));
    end
    return 2'b00;
  endfunction

  // Monitor: every response must match the oldest expectation of its port, on time.
  always @(negedge clk) begin
    if (reset_n) begin
      check("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p]) begin
          exp_t e;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            check($sformatf("rvalid_unexpected_p%0d", p), 64'd1, 64'd0);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata_p%0d", p), 64'(rdata[p*32 +: 32]), 64'(e.data));
            check($sformatf("err_p%0d", p), 64'(err[p]), 64'(e.err));
            check($sformatf("latency_p%0d", p), 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  end

  task automatic access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d, input bit exp_e,
                        input bit do_push);
    int   waited = 0;
    bit   granted = 0;
    req[p]          = 1'b1;
    we[p]           = w;
    addr[p*32 +: 32]  = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4]      = b;
    while (!granted && waited < 50) begin
      @(negedge clk);
      check("single_gnt", 64'(gnt), 64'(rr_pick(2'(1 << p), 0, model_stall)));
      if (gnt[p]) granted = 1;
      else        waited++;
    end
    check("gnt_seen", 64'(granted), 64'd1);
    if (granted && do_push) push(p, exp_e, exp_d);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic both_phase(input string name, input int n_gnt, input bit drop,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
    int got = 0, c0 = 0, c1 = 0, waited = 0, ptr_m = 0;
    logic [1:0] g;
    req  = 2'b11;
    we   = 2'b00;
    addr = {a1, a0};
    while (got < n_gnt && waited < 64) begin
      @(negedge clk);
      g = gnt;
      check(name, 64'(g), 64'(rr_pick(req, ptr_m, model_stall)));
      if (g[0]) begin
        push(0, 1'b0, d0); c0++; got++; ptr_m = 1;
      end else if (g[1]) begin
        push(1, 1'b0, d1); c1++; got++; ptr_m = 0;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
      if (drop) req = req & ~g;
    end
    req = 2'b00;
    check({name, "_p0_grants"}, 64'(c0), 64'(n_gnt / 2));
    check({name, "_p1_grants"}, 64'(c1), 64'(n_gnt / 2));
  endtask

  task automatic stream(input int n);
    logic [31:0] sa [3];
    logic [31:0] sd [3];
    int k = 0, stalls = 0;
    sa = '{32'h100, 32'h104, 32'h0};
    sd = '{32'hDEADBEEF, 32'hFF22FF44, 32'h12345678};
    req[0] = 1'b1;
    we[0]  = 1'b0;
    for (int i = 0; i < n; i++) begin
      addr[31:0] = sa[k % 3];
      @(negedge clk);
      check("stream_gnt", 64'(gnt), 64'(rr_pick(2'b01, 0, model_stall)));
      if (model_stall) stalls++;
      if (gnt[0]) begin
        push(0, 1'b0, sd[k % 3]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    req[0] = 1'b0;
    check("stream_grant_count", 64'(k), 64'(n - stalls));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    #1 reset_n = 1'b0;
    req = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_rdata", rdata, 64'd0);
    end
    @(posedge clk);
    #1;
    req     = 2'b00;
    reset_n = 1'b1;
    idle(1);

    // Full write on P1, then read back on P0
    access(1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1);
    access(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1);

    // Partial write; read issued the cycle after the write
    access(0, 1, 32'h104, 32'hFFFFFFFF, 4'hF, 32'h0, 0, 1);
    access(0, 1, 32'h104, 32'h11223344, 4'b0101, 32'h0, 0, 1);
    access(1, 0, 32'h104, 32'h0, 4'h0, 32'hFF22FF44, 0, 1);

    // Saturated round robin
    both_phase("rr_gnt", 8, 0, 32'h100, 32'h104, 32'hDEADBEEF, 32'hFF22FF44);

    // Range boundaries, be=0 no-op, ignored byte offset
    access(0, 1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0, 1);
    access(0, 1, 32'h4000, 32'hBAD0BAD0, 4'hF, 32'h0, 1, 1);
    access(0, 0, 32'h4000, 32'h0, 4'h0, 32'h0, 1, 1);
    access(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0, 1);
    access(1, 1, 32'h3FFC, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1);
    access(0, 0, 32'h3FFF, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1);
    access(1, 1, 32'h100, 32'h0, 4'h0, 32'h0, 0, 1);
    access(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1);
    idle(LAT + 2);

    // Reset one cycle after a grant drops that response and restarts the pointer
    access(0, 0, 32'h100, 32'h0, 4'h0, 32'h0, 0, 0);
    reset_n = 1'b0;
    req     = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check("midrst_gnt", 64'(gnt), 64'd0);
      check("midrst_rvalid", 64'(rvalid), 64'd0);
    end
    @(posedge clk);
    #1;
    req     = 2'b00;
    reset_n = 1'b1;
    idle(4);
    both_phase("post_rst_gnt", 2, 1, 32'h100, 32'h104, 32'hDEADBEEF, 32'hFF22FF44);
    access(1, 0, 32'h104, 32'h0, 4'h0, 32'hFF22FF44, 0, 1);

`ifdef TB_MEMORY_MP_STALL_EN
    stream(1000);
`else
    stream(200);
`endif

    idle(LAT + 3);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
